// File: rtl/modbus_pkg.sv
// modbus_pkg: shared Modbus RTU constants and framer state encoding.
package modbus_pkg;

    localparam logic [7:0] FC_RD_HOLD   = 8'h03;
    localparam logic [7:0] FC_RD_INPUT  = 8'h04;
    localparam logic [7:0] FC_WR_SINGLE = 8'h06;

    localparam logic [7:0] EXC_NONE      = 8'h00;
    localparam logic [7:0] EXC_ILL_FUNC  = 8'h01;
    localparam logic [7:0] EXC_ILL_VALUE = 8'h03;

    localparam logic [15:0] CRC_INIT     = 16'hFFFF;
    localparam logic [15:0] CRC_POLY     = 16'hA001;
    localparam logic [15:0] MAX_READ_QTY = 16'd125;

    typedef enum logic [1:0] {WAIT_IDLE, IDLE, RECV, CHECK} state_t;

endpackage

// File: rtl/crc16_modbus.sv
// crc16_modbus: bit-serial CRC-16/Modbus, one byte every 8 cycles, LSB first.
module crc16_modbus
    import modbus_pkg::*;
(
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        init,
    input  logic [7:0]  byte_in,
    input  logic        byte_vld,
    output logic [15:0] crc,
    output logic        busy
);

    logic [7:0] shift;
    logic [3:0] bits_left;

    assign busy = bits_left != 4'd0;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            crc       <= CRC_INIT;
            shift     <= '0;
            bits_left <= '0;
        end else if (byte_vld) begin
            shift     <= byte_in;
            bits_left <= 4'd8;
            if (init) crc <= CRC_INIT;
        end else if (busy) begin
            shift     <= shift >> 1;
            bits_left <= bits_left - 4'd1;
            crc       <= (crc >> 1) ^ ((crc[0] ^ shift[0]) ? CRC_POLY : 16'h0000);
        end else if (init) begin
            crc <= CRC_INIT;
        end
    end

endmodule

// File: rtl/modbus_req_parser.sv
// modbus_req_parser: Modbus RTU receive framer; T3.5 framing, address/CRC check,
// decode of function 03/04/06 requests into one request pulse.
module modbus_req_parser
    import modbus_pkg::*;
#(
    parameter int         CLK_FREQ  = 50000000,
    parameter int         BAUD_RATE = 115200,
    parameter logic [7:0] DEV_ADDR  = 8'h01
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic [7:0]  rx_byte,
    input  logic        rx_byte_vld,
    input  logic        tx_busy,
    output logic        req_valid,
    output logic [7:0]  func_code,
    output logic [15:0] start_addr,
    output logic [15:0] quantity,
    output logic [7:0]  exc_code,
    output logic        broadcast,
    output logic        frame_err
);

    // Above 19200 baud the silence is fixed at 1.75 ms
    localparam longint T35_L = (BAUD_RATE <= 19200)
        ? (longint'(CLK_FREQ) * 64'd77) / (longint'(BAUD_RATE) * 64'd2)
        : (longint'(CLK_FREQ) * 64'd7) / 64'd4000;
    localparam int T35_CYCLES = int'(T35_L);
    localparam int CW = $clog2(T35_CYCLES + 1);

    state_t            state, next_state;
    logic [CW-1:0]     silence_cnt;
    logic [3:0]        count;
    logic              overflow;
    logic [5:0][7:0]   frame_bytes;
    logic              silence, start, do_check, store;
    logic              crc_busy;
    logic [15:0]       crc;
    logic [7:0]        f_addr, f_func, f_exc;
    logic [15:0]       f_start, f_qty;
    logic              is_read, is_bcast, addr_hit, bad_frame, accept;

    assign silence = (silence_cnt == CW'(T35_CYCLES - 1)) && !rx_byte_vld;
    assign store   = (state == RECV) && rx_byte_vld && (count < 4'd8);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) silence_cnt <= '0;
        else if (rx_byte_vld) silence_cnt <= '0;
        else if (silence_cnt != CW'(T35_CYCLES)) silence_cnt <= silence_cnt + 1'b1;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state <= WAIT_IDLE;
        else state <= next_state;
    end

    // A byte landing in the CHECK cycle opens the next frame
    always_comb begin
        next_state = state;
        start      = 1'b0;
        do_check   = 1'b0;
        case (state)
            WAIT_IDLE: next_state = silence ? IDLE : WAIT_IDLE;
            IDLE: begin
                start      = rx_byte_vld;
                next_state = rx_byte_vld ? RECV : IDLE;
            end
            RECV: next_state = silence ? CHECK : RECV;
            CHECK: begin
                do_check   = 1'b1;
                start      = rx_byte_vld;
                next_state = rx_byte_vld ? RECV : IDLE;
            end
            default: next_state = WAIT_IDLE;
        endcase
    end

    crc16_modbus u_crc (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .init     (start),
        .byte_in  (rx_byte),
        .byte_vld (start || store),
        .crc      (crc),
        .busy     (crc_busy)
    );

    assign f_addr    = frame_bytes[0];
    assign f_func    = frame_bytes[1];
    assign f_start   = {frame_bytes[2], frame_bytes[3]};
    assign f_qty     = {frame_bytes[4], frame_bytes[5]};
    assign is_read   = (f_func == FC_RD_HOLD) || (f_func == FC_RD_INPUT);
    assign is_bcast  = f_addr == 8'h00;
    assign addr_hit  = (f_addr == DEV_ADDR) || is_bcast;
    assign bad_frame = overflow || (count != 4'd8) || crc_busy || (crc != 16'h0000);
    assign accept    = !bad_frame && addr_hit && !tx_busy && !(is_bcast && is_read);
    assign f_exc     = is_read ? (((f_qty == 16'd0) || (f_qty > MAX_READ_QTY)) ? EXC_ILL_VALUE : EXC_NONE)
                               : ((f_func == FC_WR_SINGLE) ? EXC_NONE : EXC_ILL_FUNC);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            count       <= '0;
            overflow    <= 1'b0;
            frame_bytes <= '0;
            req_valid   <= 1'b0;
            frame_err   <= 1'b0;
            func_code   <= '0;
            start_addr  <= '0;
            quantity    <= '0;
            exc_code    <= '0;
            broadcast   <= 1'b0;
        end else begin
            req_valid <= do_check && accept;
            frame_err <= do_check && bad_frame;
            if (start) begin
                frame_bytes[0] <= rx_byte;
                count          <= 4'd1;
                overflow       <= 1'b0;
            end else if (store) begin
                if (count < 4'd6) frame_bytes[count[2:0]] <= rx_byte;
                count <= count + 4'd1;
            end else if (state == RECV && rx_byte_vld) begin
                overflow <= 1'b1;
            end
            if (do_check && accept) begin
                func_code  <= f_func;
                start_addr <= f_start;
                quantity   <= f_qty;
                exc_code   <= f_exc;
                broadcast  <= is_bcast;
            end
        end
    end

endmodule

// File: tb/tb_modbus_req_parser.sv
// tb_modbus_req_parser: scoreboarded random + directed bench for the RTU request framer.
module tb_modbus_req_parser;

    localparam int CLK_FREQ  = 400000;
    localparam int BAUD_RATE = 115200;
    localparam int T35       = CLK_FREQ * 7 / 4000;

    typedef logic [7:0] bytes_t[$];
    typedef struct {
        bit          err;
        logic [7:0]  fc;
        logic [15:0] sa;
        logic [15:0] qty;
        logic [7:0]  exc;
        bit          bc;
        longint      due;
    } exp_t;

    logic        clk_in = 0, rst_n_in = 0;
    logic [7:0]  rx_byte = 0;
    logic        rx_byte_vld = 0, tx_busy = 0;
    logic        req_valid, frame_err, broadcast;
    logic [7:0]  func_code, exc_code;
    logic [15:0] start_addr, quantity;

    int     checks = 0, errors = 0;
    longint cyc = 0;
    exp_t   sb[$];
    exp_t   me, held;
    bit     synced = 0;
    bytes_t q, q2;
    logic [7:0]  r_addr, r_fc;
    logic [15:0] r_qty;
    int          r_i;

    modbus_req_parser #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .DEV_ADDR(8'h01)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rx_byte(rx_byte), .rx_byte_vld(rx_byte_vld),
        .tx_busy(tx_busy), .req_valid(req_valid), .func_code(func_code), .start_addr(start_addr),
        .quantity(quantity), .exc_code(exc_code), .broadcast(broadcast), .frame_err(frame_err)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] crc16(input bytes_t b, input int n);
        logic [15:0] c = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {8'h00, b[i]};
            for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        return c;
    endfunction

    function automatic bytes_t make_frame(input logic [7:0] a, input logic [7:0] fc,
                                          input logic [15:0] sa, input logic [15:0] qty);
        bytes_t b;
        logic [15:0] c;
        b = '{a, fc, sa[15:8], sa[7:0], qty[15:8], qty[7:0]};
        c = crc16(b, 6);
        b.push_back(c[7:0]);
        b.push_back(c[15:8]);
        return b;
    endfunction

    // Reference outcome of one complete frame, straight from the protocol rules
    task automatic predict(input bytes_t b, input bit busy, input longint last);
        exp_t e;
        bit   rd;
        e = '{default: 0};
        e.due = last + T35 + 1;
        if (b.size() != 8 || crc16(b, 6) != {b[7], b[6]}) begin
            e.err = 1;
            sb.push_back(e);
            return;
        end
        if (b[0] != 8'h01 && b[0] != 8'h00) return;
        if (busy) return;
        e.fc  = b[1];
        e.sa  = {b[2], b[3]};
        e.qty = {b[4], b[5]};
        e.bc  = b[0] == 8'h00;
        rd    = e.fc == 8'h03 || e.fc == 8'h04;
        if (e.bc && rd) return;
        e.exc = rd ? ((e.qty >= 1 && e.qty <= 125) ? 8'h00 : 8'h03) : (e.fc == 8'h06 ? 8'h00 : 8'h01);
        sb.push_back(e);
        held = e;
    endtask

    task automatic send_frame(input bytes_t b, input int spacing, input int tail);
        longint last = 0;
        bit proc = synced;
        foreach (b[i]) begin
            @(negedge clk_in);
            rx_byte = b[i];
            rx_byte_vld = 1;
            @(negedge clk_in);
            rx_byte_vld = 0;
            last = cyc;
            if (i != b.size() - 1) repeat (spacing - 2) @(negedge clk_in);
        end
        if (proc) predict(b, tx_busy, last);
        synced = tail >= T35 - 1;
        repeat (tail) @(negedge clk_in);
        if (tail >= T35 + 2) begin
            chk("hold_func", func_code, held.fc);
            chk("hold_start", start_addr, held.sa);
            chk("hold_qty", quantity, held.qty);
            chk("hold_exc", exc_code, held.exc);
            chk("hold_bcast", broadcast, held.bc);
        end
    endtask

    always @(negedge clk_in) begin
        if (rst_n_in && (req_valid || frame_err)) begin
            if (sb.size() == 0) begin
                chk("unexpected_pulse", {req_valid, frame_err}, 0);
            end else begin
                me = sb.pop_front();
                chk("pulse_kind", {req_valid, frame_err}, me.err ? 2'b01 : 2'b10);
                chk("latency", cyc, me.due);
                if (!me.err) begin
                    chk("func_code", func_code, me.fc);
                    chk("start_addr", start_addr, me.sa);
                    chk("quantity", quantity, me.qty);
                    chk("exc_code", exc_code, me.exc);
                    chk("broadcast", broadcast, me.bc);
                end
            end
        end
    end

    initial begin
        held = '{default: 0};
        repeat (3) @(negedge clk_in);
        chk("rst_req_valid", req_valid, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_func", func_code, 0);
        chk("rst_start", start_addr, 0);
        chk("rst_qty", quantity, 0);
        chk("rst_exc", exc_code, 0);
        chk("rst_bcast", broadcast, 0);
        rst_n_in = 1;
        repeat (T35 + 20) @(negedge clk_in);
        synced = 1;

        q = '{8'h01, 8'h04, 8'h00, 8'h00, 8'h00, 8'h0A, 8'h70, 8'h0D};
        send_frame(q, 12, T35 + 20);
        q = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h0A, 8'hC5, 8'hCD};
        send_frame(q, 12, T35 + 20);
        q = '{8'h01, 8'h06, 8'h00, 8'h01, 8'h00, 8'h03, 8'h98, 8'h0B};
        send_frame(q, 12, T35 + 20);
        q = '{8'h01, 8'h04, 8'h00, 8'h00, 8'h00, 8'h0A, 8'h70, 8'h0C};
        send_frame(q, 12, T35 + 20);
        q = '{8'h01, 8'h04, 8'h00, 8'h00, 8'h00, 8'h0A, 8'h70};
        send_frame(q, 12, T35 + 20);
        q = '{8'h01, 8'h04, 8'h00, 8'h00, 8'h00, 8'h0A, 8'h70, 8'h0D, 8'h55};
        send_frame(q, 12, T35 + 20);
        send_frame(make_frame(8'h02, 8'h03, 16'h0000, 16'h000A), 12, T35 + 20);
        send_frame(make_frame(8'h01, 8'h03, 16'h0010, 16'h007E), 12, T35 + 20);
        send_frame(make_frame(8'h01, 8'h03, 16'h0011, 16'h007D), 12, T35 + 20);
        send_frame(make_frame(8'h01, 8'h05, 16'h0002, 16'hFF00), 12, T35 + 20);
        send_frame(make_frame(8'h00, 8'h06, 16'h0005, 16'h0007), 12, T35 + 20);
        send_frame(make_frame(8'h00, 8'h03, 16'h0000, 16'h0001), 12, T35 + 20);
        tx_busy = 1;
        send_frame(make_frame(8'h01, 8'h04, 16'h0000, 16'h0002), 12, T35 + 20);
        tx_busy = 0;

        q  = make_frame(8'h01, 8'h03, 16'h0000, 16'h000A);
        q2 = make_frame(8'h01, 8'h06, 16'h0001, 16'h0003);
        foreach (q2[i]) q.push_back(q2[i]);
        send_frame(q, 300, T35 + 20);

        // next frame's first byte lands exactly in the CHECK cycle
        send_frame(make_frame(8'h01, 8'h04, 16'h0001, 16'h0002), 12, T35 - 1);
        send_frame(make_frame(8'h01, 8'h06, 16'h0002, 16'h0003), 12, T35 + 20);

        q = make_frame(8'h01, 8'h03, 16'h0000, 16'h0005);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_in);
            rx_byte = q[i];
            rx_byte_vld = 1;
            @(negedge clk_in);
            rx_byte_vld = 0;
            repeat (10) @(negedge clk_in);
        end
        rst_n_in = 0;
        synced = 0;
        held = '{default: 0};
        @(negedge clk_in);
        chk("midrst_func", func_code, 0);
        chk("midrst_req_valid", req_valid, 0);
        rst_n_in = 1;
        send_frame(q, 12, T35 + 20);
        send_frame(q, 12, T35 + 20);

        for (int k = 0; k < 20; k++) begin
            case ($urandom_range(0, 5))
                0, 1, 2: r_addr = 8'h01;
                3:       r_addr = 8'h00;
                4:       r_addr = 8'h02;
                default: r_addr = 8'($urandom);
            endcase
            case ($urandom_range(0, 4))
                0:       r_fc = 8'h03;
                1:       r_fc = 8'h04;
                2:       r_fc = 8'h06;
                3:       r_fc = 8'h05;
                default: r_fc = 8'($urandom);
            endcase
            case ($urandom_range(0, 4))
                0:       r_qty = 16'd0;
                1:       r_qty = 16'd1;
                2:       r_qty = 16'd125;
                3:       r_qty = 16'd126;
                default: r_qty = 16'($urandom_range(0, 200));
            endcase
            q = make_frame(r_addr, r_fc, 16'($urandom), r_qty);
            case ($urandom_range(0, 7))
                0: begin
                    r_i = $urandom_range(0, 7);
                    q[r_i] = q[r_i] ^ (8'h01 << $urandom_range(0, 7));
                end
                1:       void'(q.pop_back());
                2:       q.push_back(8'($urandom));
                default: ;
            endcase
            tx_busy = $urandom_range(0, 5) == 0;
            send_frame(q, $urandom_range(9, 30), T35 + 20);
            tx_busy = 0;
        end

        repeat (50) @(negedge clk_in);
        chk("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
